spi_slave_sync: RTL and testbench

SPI_SLAVE_SYNC -- requirements
Module: spi_slave_sync

---
 rtl/spi_pkg.sv | 14 +
 rtl/sync_chain.sv | 24 ++
 rtl/spi_slave_sync.sv | 183 ++++++++++++++++++
 tb/tb_spi_slave_sync.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the synchronous-sampling SPI slave.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // 1: data is sampled on the sclk rising edge, 0: on the falling edge.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return ~(cpol ^ cpha);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for one asynchronous input bit, with a selectable reset level.
module sync_chain #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave that oversamples sclk/cs_n/mosi in the clk domain and runs entirely on clk.
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CPOL        = 0,
  parameter int unsigned CPHA        = 0,
  parameter int unsigned MSB_FIRST   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  output logic             frame_err
);

  localparam int unsigned     CntW       = $clog2(WIDTH);
  localparam logic            CpolLvl    = (CPOL != 0);
  localparam logic            SampleRise = sample_on_rise(CPOL != 0, CPHA != 0);
  localparam logic [CntW-1:0] LastBit    = CntW'(WIDTH - 1);

  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  logic sclk_s, cs_n_s, mosi_s;

  sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(CpolLvl)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sclk),
    .q     (sclk_s)
  );

  sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cs_n),
    .q     (cs_n_s)
  );

  sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (mosi),
    .q     (mosi_s)
  );

  state_e            state_q, state_d;
  logic              sclk_q, cs_n_q;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]  rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0]  rx_data_q, rx_data_d;
  logic [WIDTH-1:0]  tx_shift_q, tx_shift_d;
  logic              rx_valid_q, rx_valid_d;
  logic              miso_q, miso_d;
  logic              tx_underrun_q, tx_underrun_d;
  logic              frame_err_q, frame_err_d;

  logic             sclk_rise, sclk_fall, in_frame;
  logic             sample_edge, shift_edge;
  logic             cs_fall, cs_rise, start, word_done, load;
  logic [WIDTH-1:0] load_word, rx_next;

  assign sclk_rise   = sclk_s & ~sclk_q;
  assign sclk_fall   = ~sclk_s & sclk_q;
  assign in_frame    = (state_q == ACTIVE) & ~cs_n_s;
  assign sample_edge = in_frame & (SampleRise ? sclk_rise : sclk_fall);
  assign shift_edge  = in_frame & (SampleRise ? sclk_fall : sclk_rise);
  assign cs_fall     = cs_n_q & ~cs_n_s;
  assign cs_rise     = ~cs_n_q & cs_n_s;
  assign start       = (state_q == IDLE) & cs_fall;
  assign word_done   = sample_edge & (bit_cnt_q == LastBit);
  assign load        = start | word_done;
  assign load_word   = tx_valid ? tx_data : '0;
  assign rx_next     = (MSB_FIRST != 0) ? {rx_shift_q[WIDTH-2:0], mosi_s}
                                        : {mosi_s, rx_shift_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cs_fall) state_d = ACTIVE;
      ACTIVE:  if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    tx_shift_d    = tx_shift_q;
    miso_d        = miso_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    frame_err_d   = 1'b0;

    if (sample_edge) begin
      if (word_done) begin
        rx_data_d  = rx_next;
        rx_valid_d = 1'b1;
        rx_shift_d = '0;
        bit_cnt_d  = '0;
      end else begin
        rx_shift_d = rx_next;
        bit_cnt_d  = bit_cnt_q + 1'b1;
      end
    end

    if (shift_edge) begin
      miso_d     = head_bit(tx_shift_q);
      tx_shift_d = shift_out(tx_shift_q);
    end

    // With CPHA=0 the master samples before any shift edge, so the first bit goes out at load.
    if (load) begin
      tx_underrun_d = ~tx_valid;
      if (start && (CPHA == 0)) begin
        miso_d     = head_bit(load_word);
        tx_shift_d = shift_out(load_word);
      end else begin
        tx_shift_d = load_word;
      end
    end

    if ((state_q == ACTIVE) && cs_rise) begin
      bit_cnt_d   = '0;
      rx_shift_d  = '0;
      frame_err_d = (bit_cnt_q != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sclk_q        <= CpolLvl;
      cs_n_q        <= 1'b1;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      tx_shift_q    <= '0;
      rx_valid_q    <= 1'b0;
      miso_q        <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sclk_q        <= sclk_s;
      cs_n_q        <= cs_n_s;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      tx_shift_q    <= tx_shift_d;
      rx_valid_q    <= rx_valid_d;
      miso_q        <= miso_d;
      tx_underrun_q <= tx_underrun_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = ~cs_n_s;
  assign tx_ready    = load;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench: three slave configurations share one SPI master driven at clk/sclk = 8.
module tb_spi_slave_sync;

  localparam int H = 4;  // clk cycles per sclk half period

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sclk_ph = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;

  logic        miso0, miso_oe0, tx_ready0, rx_valid0, tx_underrun0, frame_err0, tx_valid0;
  logic [7:0]  tx_data0, rx_data0;
  logic        miso1, miso_oe1, tx_ready1, rx_valid1, tx_underrun1, frame_err1, tx_valid1;
  logic [7:0]  tx_data1, rx_data1;
  logic        miso2, miso_oe2, tx_ready2, rx_valid2, tx_underrun2, frame_err2, tx_valid2;
  logic [15:0] tx_data2, rx_data2;

  int total = 0;
  int bad = 0;

  int rxv_cnt [3] = '{0, 0, 0};
  int txr_cnt [3] = '{0, 0, 0};
  int und_cnt [3] = '{0, 0, 0};
  int fer_cnt [3] = '{0, 0, 0};
  logic [31:0] rx_log0 [$];
  logic [31:0] rx_log1 [$];
  logic [31:0] rx_log2 [$];

  always #5 clk = ~clk;

  // Mode 0, MSB first
  spi_slave_sync #(.WIDTH(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) dut0 (
    .clk (clk), .rst_n (rst_n), .sclk (sclk_ph), .cs_n (cs_n), .mosi (mosi),
    .miso (miso0), .miso_oe (miso_oe0), .tx_data (tx_data0), .tx_valid (tx_valid0),
    .tx_ready (tx_ready0), .rx_data (rx_data0), .rx_valid (rx_valid0),
    .tx_underrun (tx_underrun0), .frame_err (frame_err0)
  );

  // Mode 3, LSB first; sclk idles high
  spi_slave_sync #(.WIDTH(8), .CPOL(1), .CPHA(1), .MSB_FIRST(0), .SYNC_STAGES(2)) dut1 (
    .clk (clk), .rst_n (rst_n), .sclk (~sclk_ph), .cs_n (cs_n), .mosi (mosi),
    .miso (miso1), .miso_oe (miso_oe1), .tx_data (tx_data1), .tx_valid (tx_valid1),
    .tx_ready (tx_ready1), .rx_data (rx_data1), .rx_valid (rx_valid1),
    .tx_underrun (tx_underrun1), .frame_err (frame_err1)
  );

  // Mode 1, 16-bit, MSB first
  spi_slave_sync #(.WIDTH(16), .CPOL(0), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2)) dut2 (
    .clk (clk), .rst_n (rst_n), .sclk (sclk_ph), .cs_n (cs_n), .mosi (mosi),
    .miso (miso2), .miso_oe (miso_oe2), .tx_data (tx_data2), .tx_valid (tx_valid2),
    .tx_ready (tx_ready2), .rx_data (rx_data2), .rx_valid (rx_valid2),
    .tx_underrun (tx_underrun2), .frame_err (frame_err2)
  );

  always @(negedge clk) begin
    if (rx_valid0) begin rxv_cnt[0] <= rxv_cnt[0] + 1; rx_log0.push_back(32'(rx_data0)); end
    if (rx_valid1) begin rxv_cnt[1] <= rxv_cnt[1] + 1; rx_log1.push_back(32'(rx_data1)); end
    if (rx_valid2) begin rxv_cnt[2] <= rxv_cnt[2] + 1; rx_log2.push_back(32'(rx_data2)); end
    if (tx_ready0) txr_cnt[0] <= txr_cnt[0] + 1;
    if (tx_ready1) txr_cnt[1] <= txr_cnt[1] + 1;
    if (tx_ready2) txr_cnt[2] <= txr_cnt[2] + 1;
    if (tx_underrun0) und_cnt[0] <= und_cnt[0] + 1;
    if (tx_underrun1) und_cnt[1] <= und_cnt[1] + 1;
    if (tx_underrun2) und_cnt[2] <= und_cnt[2] + 1;
    if (frame_err0) fer_cnt[0] <= fer_cnt[0] + 1;
    if (frame_err1) fer_cnt[1] <= fer_cnt[1] + 1;
    if (frame_err2) fer_cnt[2] <= fer_cnt[2] + 1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic miso_of(input int sel);
    case (sel)
      0:       return miso0;
      1:       return miso1;
      default: return miso2;
    endcase
  endfunction

  // Word -> bit stream in wire order (stream bit 0 goes first).
  function automatic logic [63:0] to_stream(input logic [31:0] w, input int width,
                                            input bit msb_first);
    logic [63:0] s = '0;
    for (int i = 0; i < width; i++) s[i] = msb_first ? w[width-1-i] : w[i];
    return s;
  endfunction

  function automatic logic [31:0] from_stream(input logic [63:0] s, input int off,
                                              input int width, input bit msb_first);
    logic [31:0] w = '0;
    for (int i = 0; i < width; i++) begin
      if (msb_first) w[width-1-i] = s[off+i];
      else           w[i] = s[off+i];
    end
    return w;
  endfunction

  // Master: leading edge is always a rise of sclk_ph; each DUT inverts per its CPOL.
  task automatic spi_frame(input int sel, input int cpha, input int nbits,
                           input logic [63:0] tx_bits, input bit end_frame,
                           output logic [63:0] rx_bits);
    rx_bits = '0;
    @(negedge clk);
    cs_n = 1'b0;
    if (cpha == 0) mosi = tx_bits[0];
    wait_clks(H);
    for (int i = 0; i < nbits; i++) begin
      sclk_ph = 1'b1;
      if (cpha == 0) rx_bits[i] = miso_of(sel);
      else           mosi = tx_bits[i];
      wait_clks(H);
      sclk_ph = 1'b0;
      if (cpha == 0) begin
        if (i + 1 < nbits) mosi = tx_bits[i+1];
      end else begin
        rx_bits[i] = miso_of(sel);
      end
      wait_clks(H);
    end
    if (end_frame) begin
      cs_n = 1'b1;
      wait_clks(2 * H);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    wait_clks(3);
    total++;
    if ({miso0, miso_oe0, rx_valid0, tx_ready0, tx_underrun0, frame_err0} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl0: got %b want 000000",
               {miso0, miso_oe0, rx_valid0, tx_ready0, tx_underrun0, frame_err0});
    end
    total++;
    if (rx_data0 !== 8'h00) begin
      bad++; $display("FAIL reset_rx_data0: got %h want 00", rx_data0);
    end
    total++;
    if ({miso1, miso_oe1, miso2, miso_oe2} !== 4'b0) begin
      bad++; $display("FAIL reset_miso12: got %b want 0000", {miso1, miso_oe1, miso2, miso_oe2});
    end
    rst_n = 1'b1;
    wait_clks(4);
    total++;
    if (miso_oe0 !== 1'b0) begin
      bad++; $display("FAIL idle_miso_oe0: got %b want 0", miso_oe0);
    end
  endtask

  task automatic test_mode0;
    logic [63:0] rxb;
    int r0, t0, u0, f0;
    tx_data0 = 8'h3C; tx_valid0 = 1'b1;
    r0 = rxv_cnt[0]; t0 = txr_cnt[0]; u0 = und_cnt[0]; f0 = fer_cnt[0];
    spi_frame(0, 0, 8, to_stream(32'hA5, 8, 1), 1'b1, rxb);
    total++;
    if (rx_data0 !== 8'hA5) begin bad++; $display("FAIL m0_rx_data: got %h want a5", rx_data0); end
    total++;
    if (rxv_cnt[0] - r0 != 1) begin
      bad++; $display("FAIL m0_rx_valid: got %0d pulses want 1", rxv_cnt[0] - r0);
    end
    total++;
    if (from_stream(rxb, 0, 8, 1) !== 32'h3C) begin
      bad++; $display("FAIL m0_miso: got %h want 3c", from_stream(rxb, 0, 8, 1));
    end
    // Loads at cs_n fall and again at the completed word.
    total++;
    if (txr_cnt[0] - t0 != 2) begin
      bad++; $display("FAIL m0_tx_ready: got %0d pulses want 2", txr_cnt[0] - t0);
    end
    total++;
    if ((und_cnt[0] - u0 != 0) || (fer_cnt[0] - f0 != 0)) begin
      bad++; $display("FAIL m0_errors: got und=%0d ferr=%0d want 0 0",
                      und_cnt[0] - u0, fer_cnt[0] - f0);
    end
  endtask

  task automatic test_underrun;
    logic [63:0] rxb;
    int r0, u0;
    tx_valid0 = 1'b0; tx_data0 = 8'hFF;
    r0 = rxv_cnt[0]; u0 = und_cnt[0];
    fork
      spi_frame(0, 0, 8, to_stream(32'h5C, 8, 1), 1'b1, rxb);
      begin wait_clks(8); tx_data0 = 8'hC3; tx_valid0 = 1'b1; end
    join
    total++;
    if (und_cnt[0] - u0 != 1) begin
      bad++; $display("FAIL ur_pulses: got %0d want 1", und_cnt[0] - u0);
    end
    total++;
    if (from_stream(rxb, 0, 8, 1) !== 32'h00) begin
      bad++; $display("FAIL ur_miso: got %h want 00", from_stream(rxb, 0, 8, 1));
    end
    total++;
    if ((rx_data0 !== 8'h5C) || (rxv_cnt[0] - r0 != 1)) begin
      bad++; $display("FAIL ur_rx: got %h/%0d want 5c/1", rx_data0, rxv_cnt[0] - r0);
    end
  endtask

  task automatic test_frame_err;
    logic [63:0] rxb;
    int r0, f0;
    tx_data0 = 8'h3C; tx_valid0 = 1'b1;
    r0 = rxv_cnt[0]; f0 = fer_cnt[0];
    spi_frame(0, 0, 5, 64'h1F, 1'b1, rxb);
    total++;
    if (fer_cnt[0] - f0 != 1) begin
      bad++; $display("FAIL fe_pulse: got %0d want 1", fer_cnt[0] - f0);
    end
    total++;
    if ((rxv_cnt[0] - r0 != 0) || (rx_data0 !== 8'h5C)) begin
      bad++; $display("FAIL fe_discard: got %0d pulses data %h want 0 pulses data 5c",
                      rxv_cnt[0] - r0, rx_data0);
    end
    f0 = fer_cnt[0];
    spi_frame(0, 0, 8, to_stream(32'h3D, 8, 1), 1'b1, rxb);
    total++;
    if ((rx_data0 !== 8'h3D) || (rxv_cnt[0] - r0 != 1) || (fer_cnt[0] - f0 != 0)) begin
      bad++; $display("FAIL fe_recover: got %h/%0d/%0d want 3d/1/0",
                      rx_data0, rxv_cnt[0] - r0, fer_cnt[0] - f0);
    end
    total++;
    if (from_stream(rxb, 0, 8, 1) !== 32'h3C) begin
      bad++; $display("FAIL fe_recover_miso: got %h want 3c", from_stream(rxb, 0, 8, 1));
    end
  endtask

  task automatic test_reset_mid_word;
    logic [63:0] rxb;
    int r0, f0;
    tx_data0 = 8'h96; tx_valid0 = 1'b1;
    spi_frame(0, 0, 4, 64'hF, 1'b0, rxb);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({miso0, miso_oe0, rx_valid0, tx_ready0, tx_underrun0, frame_err0} !== 6'b0) begin
      bad++;
      $display("FAIL rst_mid_ctrl: got %b want 000000",
               {miso0, miso_oe0, rx_valid0, tx_ready0, tx_underrun0, frame_err0});
    end
    total++;
    if (rx_data0 !== 8'h00) begin
      bad++; $display("FAIL rst_mid_rx_data: got %h want 00", rx_data0);
    end
    cs_n = 1'b1; sclk_ph = 1'b0;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(4);
    r0 = rxv_cnt[0]; f0 = fer_cnt[0];
    spi_frame(0, 0, 8, to_stream(32'h5A, 8, 1), 1'b1, rxb);
    total++;
    if ((rx_data0 !== 8'h5A) || (rxv_cnt[0] - r0 != 1) || (fer_cnt[0] - f0 != 0)) begin
      bad++; $display("FAIL rst_mid_rx: got %h/%0d/%0d want 5a/1/0",
                      rx_data0, rxv_cnt[0] - r0, fer_cnt[0] - f0);
    end
    total++;
    if (from_stream(rxb, 0, 8, 1) !== 32'h96) begin
      bad++; $display("FAIL rst_mid_miso: got %h want 96", from_stream(rxb, 0, 8, 1));
    end
  endtask

  task automatic test_mode1_w16;
    logic [63:0] rxb;
    int r0, f0, u0;
    tx_data2 = 16'hBEEF; tx_valid2 = 1'b1;
    r0 = rxv_cnt[2]; f0 = fer_cnt[2]; u0 = und_cnt[2];
    spi_frame(2, 1, 16, to_stream(32'hBEEF, 16, 1), 1'b1, rxb);
    total++;
    if ((rx_data2 !== 16'hBEEF) || (rxv_cnt[2] - r0 != 1)) begin
      bad++; $display("FAIL w16_rx: got %h/%0d want beef/1", rx_data2, rxv_cnt[2] - r0);
    end
    total++;
    if (from_stream(rxb, 0, 16, 1) !== 32'hBEEF) begin
      bad++; $display("FAIL w16_miso: got %h want beef", from_stream(rxb, 0, 16, 1));
    end
    total++;
    if ((fer_cnt[2] - f0 != 0) || (und_cnt[2] - u0 != 0)) begin
      bad++; $display("FAIL w16_errors: got ferr=%0d und=%0d want 0 0",
                      fer_cnt[2] - f0, und_cnt[2] - u0);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] rxb;
    int r0, t0, f0;
    tx_data1 = 8'h4B; tx_valid1 = 1'b1;
    r0 = rxv_cnt[1]; t0 = txr_cnt[1]; f0 = fer_cnt[1];
    spi_frame(1, 1, 16, to_stream(32'h81, 8, 0) | (to_stream(32'h7E, 8, 0) << 8), 1'b1, rxb);
    total++;
    if (rxv_cnt[1] - r0 != 2) begin
      bad++; $display("FAIL b2b_rx_count: got %0d want 2", rxv_cnt[1] - r0);
    end else begin
      total++;
      if ((rx_log1[r0] !== 32'h81) || (rx_log1[r0+1] !== 32'h7E)) begin
        bad++; $display("FAIL b2b_rx_order: got %h,%h want 81,7e", rx_log1[r0], rx_log1[r0+1]);
      end
    end
    // One load per transmitted word, plus the reload on the final word completion.
    total++;
    if (txr_cnt[1] - t0 != 3) begin
      bad++; $display("FAIL b2b_tx_ready: got %0d want 3", txr_cnt[1] - t0);
    end
    total++;
    if (fer_cnt[1] - f0 != 0) begin
      bad++; $display("FAIL b2b_frame_err: got %0d want 0", fer_cnt[1] - f0);
    end
    total++;
    if ((from_stream(rxb, 0, 8, 0) !== 32'h4B) || (from_stream(rxb, 8, 8, 0) !== 32'h4B)) begin
      bad++; $display("FAIL b2b_miso: got %h,%h want 4b,4b",
                      from_stream(rxb, 0, 8, 0), from_stream(rxb, 8, 8, 0));
    end
  endtask

  initial begin
    tx_data0 = '0; tx_valid0 = 1'b0;
    tx_data1 = '0; tx_valid1 = 1'b0;
    tx_data2 = '0; tx_valid2 = 1'b0;
    #1;
    test_reset();
    test_mode0();
    test_underrun();
    test_frame_err();
    test_reset_mid_word();
    test_mode1_w16();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
